// File: rtl/mem_arbiter_if.sv
// Bus bundle between the IF/DM requesters, the shared 16-bit memory and mem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [15:0]           if_rdata;
  logic                  if_done;
  logic                  if_err;

  logic                  dm_req;
  logic                  dm_wr;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [15:0]           dm_wdata;
  logic [15:0]           dm_rdata;
  logic                  dm_done;
  logic                  dm_err;

  logic                  mem_enable;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_data_in;
  logic [15:0]           mem_data_out;

  logic                  busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_data_out,
    output if_rdata, if_done, if_err, dm_rdata, dm_done, dm_err,
           mem_enable, mem_wr, mem_addr, mem_data_in, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_data_out,
    input  if_rdata, if_done, if_err, dm_rdata, dm_done, dm_err,
           mem_enable, mem_wr, mem_addr, mem_data_in, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and load/store accesses onto one single-port memory:
// IDLE accepts one request, GRANT drives the memory for one cycle, DONE pulses completion.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

  state_t                state;
  logic [CNT_W-1:0]      starve_cnt;
  logic                  owner_dm;
  logic                  lat_wr;
  logic                  lat_mis;

  logic                  mem_enable_q;
  logic                  mem_wr_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [15:0]           mem_data_q;

  logic [15:0]           if_rdata_q;
  logic [15:0]           dm_rdata_q;
  logic                  if_done_q;
  logic                  if_err_q;
  logic                  dm_done_q;
  logic                  dm_err_q;

  logic                  pick_if;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [15:0]           sel_wdata;

  // IF only beats a pending DM request once DM has won STARVE_LIMIT times in a row.
  always_comb begin
    pick_if   = bus.if_req && (!bus.dm_req || starve_cnt == LIMIT);
    sel_wr    = pick_if ? 1'b0 : bus.dm_wr;
    sel_addr  = pick_if ? bus.if_addr : bus.dm_addr;
    sel_wdata = pick_if ? 16'h0000 : bus.dm_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      owner_dm     <= 1'b0;
      lat_wr       <= 1'b0;
      lat_mis      <= 1'b0;
      mem_enable_q <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_done_q    <= 1'b0;
      if_err_q     <= 1'b0;
      dm_done_q    <= 1'b0;
      dm_err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.if_req || pick_if) begin
            starve_cnt <= '0;
          end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
          if (bus.if_req || bus.dm_req) begin
            owner_dm     <= !pick_if;
            lat_wr       <= sel_wr;
            lat_mis      <= sel_addr[0];
            mem_enable_q <= !sel_addr[0];
            mem_wr_q     <= sel_wr && !sel_addr[0];
            mem_addr_q   <= sel_addr[0] ? '0 : sel_addr;
            mem_data_q   <= sel_addr[0] ? '0 : sel_wdata;
            state        <= GRANT;
          end
        end
        GRANT: begin
          mem_enable_q <= 1'b0;
          mem_wr_q     <= 1'b0;
          mem_addr_q   <= '0;
          mem_data_q   <= '0;
          // A misaligned access never touched memory, so its owner sees zero data.
          if (owner_dm) begin
            dm_done_q <= 1'b1;
            dm_err_q  <= lat_mis;
            if (lat_mis) begin
              dm_rdata_q <= '0;
            end else if (!lat_wr) begin
              dm_rdata_q <= bus.mem_data_out;
            end
          end else begin
            if_done_q <= 1'b1;
            if_err_q  <= lat_mis;
            if_rdata_q <= lat_mis ? 16'h0000 : bus.mem_data_out;
          end
          state <= DONE;
        end
        DONE: begin
          if_done_q <= 1'b0;
          if_err_q  <= 1'b0;
          dm_done_q <= 1'b0;
          dm_err_q  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gating by rst keeps a reset landing in GRANT from committing a write.
  assign bus.mem_enable  = mem_enable_q && !rst;
  assign bus.mem_wr      = mem_wr_q && !rst;
  assign bus.mem_addr    = rst ? '0 : mem_addr_q;
  assign bus.mem_data_in = rst ? 16'h0000 : mem_data_q;

  assign bus.if_rdata = if_rdata_q;
  assign bus.if_done  = if_done_q;
  assign bus.if_err   = if_err_q;
  assign bus.dm_rdata = dm_rdata_q;
  assign bus.dm_done  = dm_done_q;
  assign bus.dm_err   = dm_err_q;
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a word memory model plus a transaction-timeline reference model,
// driven by directed scenarios followed by randomized requests and occasional resets.
module tb_mem_arbiter;
  localparam int AW  = 16;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW)) bus();

  mem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Physical memory seen by the DUT (word-indexed, addresses kept below 0x200).
  logic [15:0] phys [0:255];
  assign bus.mem_data_out = phys[bus.mem_addr[8:1]];
  always @(posedge clk) begin
    if (bus.mem_enable && bus.mem_wr) phys[bus.mem_addr[8:1]] <= bus.mem_data_in;
  end

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: one in-flight access described by its GRANT cycle number.
  logic [15:0] ref_mem [0:255];
  int          cyc = 0;
  bit          tx_on = 1'b0;
  int          tx_start = 0;
  bit          tx_dm = 1'b0;
  bit          tx_wr = 1'b0;
  logic [15:0] tx_addr = '0;
  logic [15:0] tx_wdata = '0;
  int          starve = 0;
  logic [15:0] m_if_rdata = '0;
  logic [15:0] m_dm_rdata = '0;
  int          grants[$];

  task automatic model_edge();
    bit take_if;
    if (rst) begin
      tx_on = 1'b0;
      starve = 0;
      m_if_rdata = '0;
      m_dm_rdata = '0;
    end else if (tx_on && cyc - tx_start == 1) begin
      tx_on = 1'b0;
    end else if (tx_on) begin
      if (tx_addr[0]) begin
        if (tx_dm) m_dm_rdata = '0; else m_if_rdata = '0;
      end else if (tx_wr) begin
        ref_mem[tx_addr[8:1]] = tx_wdata;
      end else if (tx_dm) begin
        m_dm_rdata = ref_mem[tx_addr[8:1]];
      end else begin
        m_if_rdata = ref_mem[tx_addr[8:1]];
      end
    end else begin
      take_if = bus.if_req && (!bus.dm_req || starve == LIM);
      if (!bus.if_req || take_if) starve = 0;
      else starve = (starve < LIM) ? starve + 1 : LIM;
      if (bus.if_req || bus.dm_req) begin
        tx_on    = 1'b1;
        tx_start = cyc + 1;
        tx_dm    = !take_if;
        tx_wr    = take_if ? 1'b0 : bus.dm_wr;
        tx_addr  = take_if ? bus.if_addr : bus.dm_addr;
        tx_wdata = take_if ? 16'h0000 : bus.dm_wdata;
      end
    end
    cyc++;
  endtask

  task automatic check_outputs();
    bit in_grant, in_done, e_en;
    in_grant = tx_on && (cyc == tx_start);
    in_done  = tx_on && (cyc == tx_start + 1);
    e_en     = in_grant && !tx_addr[0] && !rst;
    check_val("mem_enable", bus.mem_enable, e_en);
    check_val("mem_wr", bus.mem_wr, e_en && tx_wr);
    check_val("mem_addr", bus.mem_addr, e_en ? tx_addr : 16'h0000);
    check_val("mem_data_in", bus.mem_data_in, e_en ? tx_wdata : 16'h0000);
    check_val("busy", bus.busy, tx_on);
    check_val("if_done", bus.if_done, in_done && !tx_dm);
    check_val("dm_done", bus.dm_done, in_done && tx_dm);
    if (in_done && !tx_dm) check_val("if_err", bus.if_err, tx_addr[0]);
    if (in_done && tx_dm) check_val("dm_err", bus.dm_err, tx_addr[0]);
    check_val("if_rdata", bus.if_rdata, m_if_rdata);
    check_val("dm_rdata", bus.dm_rdata, m_dm_rdata);
    if (bus.dm_done) grants.push_back(1);
    if (bus.if_done) grants.push_back(0);
  endtask

  task automatic step(input bit r, input bit iq, input logic [15:0] ia, input bit dq,
                      input bit dw, input logic [15:0] da, input logic [15:0] dd);
    @(posedge clk);
    model_edge();
    #1;
    rst          = r;
    bus.if_req   = iq;
    bus.if_addr  = ia;
    bus.dm_req   = dq;
    bus.dm_wr    = dw;
    bus.dm_addr  = da;
    bus.dm_wdata = dd;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    a = 16'($urandom_range(0, 63)) & 16'hFFFE;
    if ($urandom_range(0, 7) == 0) a[0] = 1'b1;
    return a;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      phys[i]    = '0;
      ref_mem[i] = '0;
    end
    rst          = 1'b1;
    bus.if_req   = 1'b1;
    bus.if_addr  = 16'h0002;
    bus.dm_req   = 1'b1;
    bus.dm_wr    = 1'b0;
    bus.dm_addr  = 16'h0004;
    bus.dm_wdata = 16'h0000;

    // Reset held two cycles with both requests high, then released.
    step(1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 16'h0004, 16'h0);
    step(1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 16'h0004, 16'h0);
    step(1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 16'h0004, 16'h0);
    idle(1);
    check_val("rst_first_grant", bus.mem_enable, 1'b1);
    idle(3);

    // DM write 0xBEEF to 0x0010, then read it back.
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0010, 16'hBEEF);
    idle(1);
    check_val("wr_mem_wr", bus.mem_wr, 1'b1);
    check_val("wr_mem_addr", bus.mem_addr, 16'h0010);
    idle(1);
    check_val("wr_dm_done", bus.dm_done, 1'b1);
    idle(1);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0010, 16'h0);
    idle(2);
    check_val("rd_dm_done", bus.dm_done, 1'b1);
    check_val("rd_beef", bus.dm_rdata, 16'hBEEF);
    idle(1);

    // Misaligned IF read.
    step(1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 16'h0, 16'h0);
    idle(1);
    check_val("mis_mem_enable", bus.mem_enable, 1'b0);
    idle(1);
    check_val("mis_if_done", bus.if_done, 1'b1);
    check_val("mis_if_err", bus.if_err, 1'b1);
    check_val("mis_if_rdata", bus.if_rdata, 16'h0000);
    idle(1);

    // Both requesters held high: DM x4, then IF, repeating.
    grants.delete();
    repeat (30) step(1'b0, 1'b1, 16'h0040, 1'b1, 1'b0, 16'h0042, 16'h0);
    idle(3);
    check_val("starve_count", grants.size(), 10);
    for (int i = 0; i < 10 && i < grants.size(); i++)
      check_val($sformatf("starve_order%0d", i), grants[i], (i % 5 == 4) ? 0 : 1);

    // Reset during the GRANT of a write must leave memory untouched.
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0020, 16'h5555);
    idle(3);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0020, 16'h1234);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    check_val("rstw_mem_wr", bus.mem_wr, 1'b0);
    idle(1);
    check_val("rstw_no_done1", bus.dm_done, 1'b0);
    idle(1);
    check_val("rstw_no_done2", bus.dm_done, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0);
    idle(2);
    check_val("rstw_old_value", bus.dm_rdata, 16'h5555);
    idle(1);

    // Randomized traffic with occasional resets.
    repeat (1500) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, rand_addr(),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, rand_addr(),
           16'($urandom));
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
